// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch stage and the downstream decoder:
// instruction width, field positions inside the 8-bit instruction word,
// opcode constants and small field-extraction helpers.
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int INST_W   = 8;

    // Instruction layout: op[7:6] src1[5:4] src2[3:2] dest[1:0]
    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 6;
    localparam int SRC1_MSB = 5;
    localparam int SRC1_LSB = 4;
    localparam int SRC2_MSB = 3;
    localparam int SRC2_LSB = 2;
    localparam int DEST_MSB = 1;
    localparam int DEST_LSB = 0;

    typedef enum logic [1:0] {
        OPC_ADD = 2'b00,
        OPC_SUB = 2'b01,
        OPC_AND = 2'b10,
        OPC_MOV = 2'b11
    } opcode_e;

    function automatic opcode_e inst_op(input logic [INST_W-1:0] i_inst);
        return opcode_e'(i_inst[OP_MSB:OP_LSB]);
    endfunction

    function automatic logic [1:0] inst_dest(input logic [INST_W-1:0] i_inst);
        return i_inst[DEST_MSB:DEST_LSB];
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
// Valid/ready instruction handshake between fetch (master) and decode (slave).
//   inst_valid : head of the prefetch queue is valid
//   inst_ready : decoder accepts the head this cycle
//   inst       : head instruction word
//   inst_pc    : address the head instruction was fetched from
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int ADDR_W = 4
);
    import fetch_pkg::*;

    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_queue_mem.sv
// ---------------------------------------------------------------------------
// inst_mem
// 2**ADDR_W x 8 instruction memory. Synchronous write port, synchronous read
// port with a registered output (one-cycle latency). A write in the same
// cycle suppresses the read, so writes always win over fetch.
// Ports:
//   clk               rising-edge clock
//   i_we/i_waddr/i_wdata  write strobe, address, data
//   i_re/i_raddr      read strobe, address
//   o_rdata           read data, valid the cycle after i_re
// ---------------------------------------------------------------------------
module inst_mem
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [INST_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [INST_W-1:0] o_rdata
);

    logic [INST_W-1:0] r_mem [2**ADDR_W];
    logic [INST_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re && !i_we)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction fetch stage: program counter, instruction memory and a DEPTH
// entry prefetch queue presented to the decoder over fetch_queue_if.
// Optional feature macro: FETCH_PERF_EN adds o_stall_cycles, a saturating
// count of cycles with fetch enabled and no valid instruction at the head.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_en                     fetch enable (queue keeps draining when low)
//   i_redirect_valid/_pc     flush queue and restart fetch at _pc
//   i_prog_we/_addr/_data    instruction memory write port
//   o_stall_cycles           stall counter (FETCH_PERF_EN only)
//   fq                       instruction handshake (master side)
// ---------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_prog_we,
    input  logic [ADDR_W-1:0] i_prog_addr,
    input  logic [INST_W-1:0] i_prog_data,
`ifdef FETCH_PERF_EN
    output logic [15:0]       o_stall_cycles,
`endif
    fetch_queue_if.master     fq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic [INST_W-1:0] r_q_data [DEPTH];
    logic [ADDR_W-1:0] r_q_pc   [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic [CNT_W:0]    w_occupancy;
    logic [INST_W-1:0] w_rdata;

    // Occupancy counts the in-flight word so the queue can never overflow
    // when it lands.
    assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_issue     = i_en & ~i_prog_we & ~i_redirect_valid
                       & (w_occupancy < (CNT_W+1)'(DEPTH));
    assign w_valid     = (r_count != '0);
    assign w_push      = r_inflight & ~i_redirect_valid;
    assign w_pop       = w_valid & fq.inst_ready;

    inst_mem #(
        .ADDR_W (ADDR_W)
    ) u_inst_mem (
        .clk     (clk),
        .i_we    (i_prog_we),
        .i_waddr (i_prog_addr),
        .i_wdata (i_prog_data),
        .i_re    (w_issue),
        .i_raddr (r_pc),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_q_data[k] <= '0;
                r_q_pc[k]   <= '0;
            end
        end else if (i_redirect_valid) begin
            // Everything queued or in flight is dropped; a pop in this
            // cycle has already been taken by the decoder.
            r_pc       <= i_redirect_pc;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_tail     <= r_head;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc          <= r_pc + ADDR_W'(1);
                r_inflight_pc <= r_pc;
            end
            if (w_push) begin
                r_q_data[r_tail] <= w_rdata;
                r_q_pc[r_tail]   <= r_inflight_pc;
                r_tail           <= r_tail + PTR_W'(1);
            end
            if (w_pop)
                r_head <= r_head + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Outputs come straight from queue registers selected by the head
    // pointer, so inst_ready has no combinational path to inst_valid.
    assign fq.inst_valid = w_valid;
    assign fq.inst       = r_q_data[r_head];
    assign fq.inst_pc    = r_q_pc[r_head];

`ifdef FETCH_PERF_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cycles <= '0;
        else if (i_en && !w_valid && r_stall_cycles != 16'hFFFF)
            r_stall_cycles <= r_stall_cycles + 16'd1;
    end

    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Self-checking bench for fetch_queue. A reference model tracks the memory
// image, the next program address the decoder must receive, and the
// saturating stall count (FETCH_PERF_EN builds). Directed steps cover
// latency, back-pressure, redirect, wrap-around and mid-run reset; a random
// phase mixes enable, ready, redirects and memory writes.
// ---------------------------------------------------------------------------
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic              en;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [INST_W-1:0] prog_data;
`ifdef FETCH_PERF_EN
    logic [15:0]       stall_cycles;
`endif

    fetch_queue_if #(.ADDR_W(ADDR_W)) fq ();

    fetch_queue #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_en             (en),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_prog_we        (prog_we),
        .i_prog_addr      (prog_addr),
        .i_prog_data      (prog_data),
`ifdef FETCH_PERF_EN
        .o_stall_cycles   (stall_cycles),
`endif
        .fq               (fq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int accepts = 0;

    logic [INST_W-1:0] tb_mem [2**ADDR_W];
    logic [ADDR_W-1:0] exp_pc;
    logic [15:0]       stall_model;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock. Inputs set by the caller apply at the coming edge;
    // the model is updated from the same inputs and the current outputs.
    task automatic step();
        logic              hold_pend;
        logic [ADDR_W-1:0] hold_pc;
        logic [INST_W-1:0] hold_inst;
        if (!rst && fq.inst_valid && fq.inst_ready) begin
            chk("accept_pc", 32'(fq.inst_pc), 32'(exp_pc));
            chk("accept_inst", 32'(fq.inst), 32'(tb_mem[exp_pc]));
            exp_pc = exp_pc + 4'd1;
            accepts++;
        end
        if (!rst && redirect_valid)
            exp_pc = redirect_pc;
        if (!rst && en && !fq.inst_valid && stall_model != 16'hFFFF)
            stall_model = stall_model + 16'd1;
        if (prog_we)
            tb_mem[prog_addr] = prog_data;
        hold_pend = !rst && fq.inst_valid && !fq.inst_ready && !redirect_valid;
        hold_pc   = fq.inst_pc;
        hold_inst = fq.inst;
        @(negedge clk);
        if (hold_pend) begin
            chk("hold_valid", 32'(fq.inst_valid), 32'd1);
            chk("hold_pc", 32'(fq.inst_pc), 32'(hold_pc));
            chk("hold_inst", 32'(fq.inst), 32'(hold_inst));
        end
`ifdef FETCH_PERF_EN
        chk("stall_cycles", 32'(stall_cycles), 32'(stall_model));
`endif
    endtask

    initial begin
        int drained;
        int acc_start;

        rst            = 1'b1;
        en             = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        prog_we        = 1'b0;
        prog_addr      = '0;
        prog_data      = '0;
        fq.inst_ready  = 1'b0;
        exp_pc         = '0;
        stall_model    = '0;

        #1;
        chk("reset_valid", 32'(fq.inst_valid), 32'd0);
        chk("reset_inst", 32'(fq.inst), 32'd0);
        chk("reset_pc", 32'(fq.inst_pc), 32'd0);
`ifdef FETCH_PERF_EN
        chk("reset_stall", 32'(stall_cycles), 32'd0);
`endif
        @(negedge clk);

        // Program memory while held in reset.
        for (int a = 0; a < 2**ADDR_W; a++) begin
            prog_we   = 1'b1;
            prog_addr = ADDR_W'(a);
            prog_data = (a < 4) ? INST_W'(8'h11 * (a + 1)) : INST_W'($urandom);
            step();
        end
        prog_we = 1'b0;

        // First instruction: two-edge latency, then one per cycle.
        rst = 1'b0;
        en = 1'b1;
        fq.inst_ready = 1'b1;
        step();
        chk("first_lat_valid", 32'(fq.inst_valid), 32'd0);
        step();
        chk("first_valid", 32'(fq.inst_valid), 32'd1);
        chk("first_inst", 32'(fq.inst), 32'h11);
        chk("first_pc", 32'(fq.inst_pc), 32'd0);
`ifdef FETCH_PERF_EN
        chk("stall_streaming", 32'(stall_cycles), 32'd2);
`endif
        for (int i = 1; i < 4; i++) begin
            step();
            chk("stream_valid", 32'(fq.inst_valid), 32'd1);
            chk("stream_inst", 32'(fq.inst), 32'(8'h11 * (i + 1)));
            chk("stream_pc", 32'(fq.inst_pc), 32'(i));
        end

        // Back-pressure: queue fills, head holds; then drain with fetch off.
        fq.inst_ready = 1'b0;
        repeat (10) step();
        chk("full_head_pc", 32'(fq.inst_pc), 32'd3);
        en = 1'b0;
        fq.inst_ready = 1'b1;
        drained = 0;
        for (int i = 0; i < 20; i++) begin
            if (!fq.inst_valid) break;
            drained++;
            step();
        end
        chk("drain_count", 32'(drained), 32'(DEPTH));
        chk("drain_empty", 32'(fq.inst_valid), 32'd0);

        // Redirect while the queue holds later addresses.
        en = 1'b1;
        fq.inst_ready = 1'b0;
        repeat (6) step();
        chk("refill_valid", 32'(fq.inst_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 4'hA;
        step();
        redirect_valid = 1'b0;
        fq.inst_ready  = 1'b1;
        chk("redir_flush", 32'(fq.inst_valid), 32'd0);
        step();
        chk("redir_lat_valid", 32'(fq.inst_valid), 32'd0);
        step();
        chk("redir_valid", 32'(fq.inst_valid), 32'd1);
        chk("redir_pc0", 32'(fq.inst_pc), 32'hA);
        step();
        chk("redir_pc1", 32'(fq.inst_pc), 32'hB);

        // Address wrap-around.
        redirect_valid = 1'b1;
        redirect_pc    = 4'hE;
        step();
        redirect_valid = 1'b0;
        chk("wrap_flush", 32'(fq.inst_valid), 32'd0);
        step();
        step();
        chk("wrap_pc_e", 32'(fq.inst_pc), 32'hE);
        step();
        chk("wrap_pc_f", 32'(fq.inst_pc), 32'hF);
        step();
        chk("wrap_pc_0", 32'(fq.inst_pc), 32'h0);
        step();
        chk("wrap_pc_1", 32'(fq.inst_pc), 32'h1);

        // Random mix; memory writes always paired with a redirect.
        acc_start = accepts;
        repeat (400) begin
            en             = ($urandom % 4) != 0;
            fq.inst_ready  = ($urandom % 3) != 0;
            redirect_valid = ($urandom % 20) == 0;
            redirect_pc    = ADDR_W'($urandom);
            prog_we        = redirect_valid && ($urandom % 2 == 0);
            prog_addr      = ADDR_W'($urandom);
            prog_data      = INST_W'($urandom);
            step();
        end
        redirect_valid = 1'b0;
        prog_we        = 1'b0;
        chk("random_progress", 32'(accepts - acc_start > 50), 32'd1);

        // Reset with three entries queued and one read in flight.
        en             = 1'b1;
        fq.inst_ready  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = '0;
        step();
        redirect_valid = 1'b0;
        repeat (4) step();
        chk("prerst_valid", 32'(fq.inst_valid), 32'd1);
        chk("prerst_pc", 32'(fq.inst_pc), 32'd0);
        rst         = 1'b1;
        exp_pc      = '0;
        stall_model = '0;
        #1;
        chk("midrst_valid", 32'(fq.inst_valid), 32'd0);
        chk("midrst_inst", 32'(fq.inst), 32'd0);
        chk("midrst_pc", 32'(fq.inst_pc), 32'd0);
`ifdef FETCH_PERF_EN
        chk("midrst_stall", 32'(stall_cycles), 32'd0);
`endif
        step();
        rst = 1'b0;
        fq.inst_ready = 1'b1;
        step();
        chk("restart_lat_valid", 32'(fq.inst_valid), 32'd0);
        step();
        chk("restart_valid", 32'(fq.inst_valid), 32'd1);
        chk("restart_pc", 32'(fq.inst_pc), 32'd0);
        chk("restart_inst", 32'(fq.inst), 32'(tb_mem[0]));

`ifdef FETCH_PERF_EN
        // Hold fetch off with a benign write until the counter saturates.
        prog_we   = 1'b1;
        prog_addr = '0;
        prog_data = tb_mem[0];
        repeat (66000) step();
        chk("stall_saturated", 32'(stall_cycles), 32'hFFFF);
        step();
        chk("stall_stays_sat", 32'(stall_cycles), 32'hFFFF);
        prog_we = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage for the 8-bit four-register CPU: holds a program counter, reads 8-bit instructions from a writable instruction memory, and buffers them in a small prefetch queue. It sits directly upstream of the decoder and presents instructions through a valid/ready handshake. A redirect input flushes the queue and restarts fetch at a new address, so the decoder stalls rather than losing instructions.

## Interface
- ADDR_W, 4, instruction address width; memory holds 2**ADDR_W words.
- DEPTH, 4, queue entries; power of two, 2..16.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; the only reset.
- en  in  1  fetch enable; 0 freezes issue, queue still drains.
- redirect_valid  in  1  flush and load PC with redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address.
- prog_we  in  1  instruction memory write strobe.
- prog_addr  in  ADDR_W  write address.
- prog_data  in  8  write data.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decoder accepts head.
- inst  out  8  head instruction: op[7:6], src1[5:4], src2[3:2], dest[1:0].
- inst_pc  out  ADDR_W  address of head instruction.
- stall_cycles  out  16  present only under FETCH_PERF_EN.

## Operation
- Reset values: pc=0, queue empty, in-flight flag 0, inst_valid=0, inst=0, inst_pc=0, stall_cycles=0. Memory contents not reset.
- Issue: in a cycle with en=1, prog_we=0, redirect_valid=0 and (count + inflight) < DEPTH, present pc to memory, set inflight=1, pc <= pc+1 mod 2**ADDR_W (wraps 2**ADDR_W-1 -> 0).
- Memory: synchronous read, one-cycle latency. Cycle after issue, data plus its address are pushed at the queue tail; inflight clears unless a new issue occurs the same cycle.
- Pop: handshake when inst_valid & inst_ready; head advances at that edge. Push and pop in the same cycle keep count unchanged.
- Queue never overflows: the issue rule reserves a slot for the in-flight word.
- inst/inst_pc driven from head register; hold value when inst_valid=0 (no X).
- Redirect: at the edge, queue emptied, in-flight word discarded, pc <= redirect_pc, no issue that cycle. A concurrent pop is counted as completed; nothing else survives.
- prog_we: write takes priority over fetch read; no issue that cycle. Already-queued words are not updated (no coherence); software redirects after writing.
- en=0: no new issue; in-flight word still lands; pops continue.
- Reset mid-operation: all state returns to reset values immediately (async).

## Timing
- First instruction: issue on the first edge after reset release with en=1; pushed on the next edge; inst_valid high after 2nd edge (2-cycle latency).
- Redirect to first valid: 2 cycles after the redirect edge... issue on edge following redirect, valid one edge later.
- Sustained throughput 1 instruction/cycle with inst_ready held high.
- inst_ready low: queue fills to DEPTH, issue stops; inst_valid, inst, inst_pc hold stable until accepted.
- No combinational path inst_ready -> inst_valid.

## Configuration
- FETCH_PERF_EN defined: stall_cycles port and 16-bit counter exist; increments each cycle en=1 and inst_valid=0; saturates at 16'hFFFF; cleared by reset only.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Package fetch_pkg: instruction field positions (OP_MSB/LSB, SRC1, SRC2, DEST slices), INST_W=8, opcode constants shared with decode.
- One sub-module: inst_mem — 2**ADDR_W x 8 array, synchronous write port, synchronous registered read port, write priority.
- Queue (head/tail pointers, count), pc, inflight, optional perf counter stay in fetch_queue.

## Test plan
- Load words 0x11,0x22,0x33,0x44 at 0..3, release reset, en=1, ready=1 -> inst_valid rises 2 cycles later; 0x11,0x22,0x33,0x44 on consecutive cycles with inst_pc 0,1,2,3.
- ready=0 for 10 cycles -> exactly DEPTH=4 entries buffered, no issue beyond that; ready=1 -> addresses 0..3 then 4 onward, none dropped or duplicated.
- Redirect to 0xA while queue holds pc 2..5 -> next accepted inst_pc is 0xA, then 0xB; pc 3..5 never appear.
- Run from pc 0xE with ADDR_W=4 -> inst_pc sequence 0xE, 0xF, 0x0, 0x1.
- Assert reset with 3 entries queued and a read in flight -> inst_valid=0 same cycle; after release, fetch restarts at pc 0.
- FETCH_PERF_EN: en=1, ready=1 from reset release -> stall_cycles=2 once streaming; force counter region to 0xFFFF -> remains 0xFFFF.
